// File: rtl/multicore_cpu_4_cpu_debug_pkg.sv
// Shared definitions for the debug on-chip memory controller.
//   - FSM state constants for the OCI memory sequencer
//   - bit positions of the fields carried in the 38-bit jdo word
//   - default start of the JTAG-read-only window
package multicore_cpu_4_cpu_debug_pkg;

  typedef logic [1:0] ocimem_state_t;

  localparam ocimem_state_t ST_IDLE  = 2'd0;
  localparam ocimem_state_t ST_J_RD  = 2'd1;
  localparam ocimem_state_t ST_J_CAP = 2'd2;
  localparam ocimem_state_t ST_J_WR  = 2'd3;

  localparam int JDO_W    = 38;
  localparam int RD_FLAG  = 35;
  localparam int ADDR_HI  = 33;
  localparam int ADDR_LO  = 26;
  localparam int WDATA_HI = 34;
  localparam int WDATA_LO = 3;

  localparam logic [7:0] DEFAULT_RO_BASE = 8'hC0;

endpackage

// File: rtl/multicore_cpu_4_cpu_debug_ocimem_ram.sv
// Single-port debug RAM, 2^ADDR_W x 32, byte-enabled writes, registered
// read data. Contents are not reset.
//   clk   : system clock
//   addr  : word address
//   we/be : write strobe and per-byte enables, wdata : write data
//   re    : read enable; q updates on the edge after re is sampled
module multicore_cpu_4_cpu_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) q <= mem[addr];
  end

endmodule

// File: rtl/multicore_cpu_4_cpu_debug_ocimem.sv
// Debug on-chip memory controller: JTAG-driven read/write sequencer for the
// debug RAM, with a CPU-side Avalon-MM slave sharing the same RAM (JTAG wins).
//   clk, reset           : system clock, async active-high reset
//   jdo, take_*          : JTAG data word and one-cycle action pulses
//   avs_*                : CPU Avalon-MM slave (fixed 1-cycle read latency)
//   MonDReg              : last JTAG read data
//   monitor_ready/error  : sequencer idle / sticky error
//
// state    | meaning
// ST_IDLE  | waiting for a take pulse; CPU port may access the RAM
// ST_J_RD  | RAM read issued at mon_addr
// ST_J_CAP | RAM q captured into MonDReg
// ST_J_WR  | jdo write data written at mon_addr (unless read-only)
module multicore_cpu_4_cpu_debug_ocimem
  import multicore_cpu_4_cpu_debug_pkg::*;
#(
  parameter int              ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] RO_BASE = DEFAULT_RO_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_t     state;
  logic [ADDR_W-1:0] mon_addr;
  logic              rd_valid;

  logic              any_take, multi_take, is_idle;
  logic              cpu_wr_acc, cpu_rd_acc, jtag_wr_ok;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we, ram_re;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_q;

  // jdo bits outside the three fields are not used by this block
  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:RD_FLAG+1], jdo[WDATA_LO-1:0]};

  assign any_take   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_take = (take_action_ocimem_a & take_no_action_ocimem_a)
                    | (take_action_ocimem_a & take_action_ocimem_b)
                    | (take_no_action_ocimem_a & take_action_ocimem_b);
  assign is_idle    = (state == ST_IDLE);

  // A pulse stalls the CPU in its own cycle so the JTAG side never loses
  // the RAM port on the following edge.
  assign avs_waitrequest = ~is_idle | any_take;
  assign cpu_wr_acc      = avs_write & ~avs_waitrequest;
  assign cpu_rd_acc      = avs_read & ~avs_write & ~avs_waitrequest;
  assign jtag_wr_ok      = (state == ST_J_WR) && (mon_addr < RO_BASE);

  // Port mux: CPU owns the RAM only while idle, JTAG otherwise.
  assign ram_addr  = is_idle ? avs_address    : mon_addr;
  assign ram_be    = is_idle ? avs_byteenable : 4'hF;
  assign ram_wdata = is_idle ? avs_writedata  : jdo[WDATA_HI:WDATA_LO];
  assign ram_we    = jtag_wr_ok | cpu_wr_acc;
  assign ram_re    = (state == ST_J_RD) | cpu_rd_acc;

  multicore_cpu_4_cpu_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .re    (ram_re),
    .q     (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      mon_addr      <= '0;
      MonDReg       <= '0;
      monitor_error <= 1'b0;
      rd_valid      <= 1'b0;
    end else begin
      rd_valid <= cpu_rd_acc;
      case (state)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            mon_addr      <= jdo[ADDR_LO +: ADDR_W];
            // a load clears the error unless it collided with another pulse
            monitor_error <= multi_take;
            state         <= jdo[RD_FLAG] ? ST_J_RD : ST_IDLE;
          end else if (take_no_action_ocimem_a) begin
            mon_addr <= mon_addr + ADDR_W'(1);
            state    <= ST_J_RD;
            if (multi_take) monitor_error <= 1'b1;
          end else if (take_action_ocimem_b) begin
            state <= ST_J_WR;
            if (multi_take) monitor_error <= 1'b1;
          end
        end
        ST_J_RD: begin
          state <= ST_J_CAP;
        end
        ST_J_CAP: begin
          MonDReg <= ram_q;
          state   <= ST_IDLE;
        end
        ST_J_WR: begin
          if (!(mon_addr < RO_BASE)) monitor_error <= 1'b1;
          mon_addr <= mon_addr + ADDR_W'(1);
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (!is_idle && any_take) monitor_error <= 1'b1;
    end
  end

  assign monitor_ready     = is_idle;
  assign avs_readdatavalid = rd_valid;
  assign avs_readdata      = rd_valid ? ram_q : 32'h0;

endmodule

// File: tb/tb_multicore_cpu_4_cpu_debug_ocimem.sv
module tb_multicore_cpu_4_cpu_debug_ocimem;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_n, take_b;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  always #5 clk = ~clk;

  multicore_cpu_4_cpu_debug_ocimem dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_n),
    .take_action_ocimem_b    (take_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_readdatavalid       (avs_readdatavalid),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  typedef struct {
    logic [31:0] dreg;
    logic        err;
    int          low;
  } jexp_t;

  jexp_t       jq[$];
  logic [31:0] cq[$];
  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_mem [256];
  logic [7:0]  m_addr;
  logic [31:0] m_dreg;
  logic        m_err;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  int    low_cnt = 0;
  jexp_t je;
  always @(negedge clk) begin
    if (avs_readdatavalid === 1'b1) begin
      if (cq.size() == 0) begin
        total++; bad++;
        $display("FAIL cpu_unexpected: got readdatavalid=1 want no pending read");
      end else begin
        check32("cpu_rdata", avs_readdata, cq.pop_front());
      end
    end
    if (monitor_ready !== 1'b1) low_cnt++;
    else if (low_cnt != 0) begin
      if (jq.size() == 0) begin
        total++; bad++;
        $display("FAIL jtag_unexpected: got busy period of %0d want none", low_cnt);
      end else begin
        je = jq.pop_front();
        check32("mon_dreg", MonDReg, je.dreg);
        check32("mon_err", {31'b0, monitor_error}, {31'b0, je.err});
        check32("busy_len", low_cnt, je.low);
      end
      low_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] addr);
    logic [37:0] j;
    j = {6'($urandom), 32'($urandom)};
    j[35] = rd;
    j[33:26] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j = {6'($urandom), 32'($urandom)};
    j[34:3] = data;
    return j;
  endfunction

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 8'hBF;
      1: return 8'hC0;
      2: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic j_a(input logic [7:0] addr, input logic rd);
    jdo = jdo_a(rd, addr);
    take_a = 1'b1;
    m_addr = addr;
    m_err  = 1'b0;
    if (rd) begin
      m_dreg = m_mem[m_addr];
      jq.push_back('{m_dreg, m_err, 2});
    end
    tick();
    take_a = 1'b0;
    if (rd) begin
      tick(); tick();
    end else begin
      check32("addr_only_ready", {31'b0, monitor_ready}, 32'd1);
      check32("addr_only_err", {31'b0, monitor_error}, 32'd0);
    end
  endtask

  task automatic j_n();
    m_addr = m_addr + 8'd1;
    m_dreg = m_mem[m_addr];
    jq.push_back('{m_dreg, m_err, 2});
    take_n = 1'b1;
    tick();
    take_n = 1'b0;
    tick(); tick();
  endtask

  task automatic j_b(input logic [31:0] data);
    jdo = jdo_b(data);
    if (m_addr < 8'hC0) m_mem[m_addr] = data;
    else m_err = 1'b1;
    m_addr = m_addr + 8'd1;
    jq.push_back('{m_dreg, m_err, 1});
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
    tick();
  endtask

  // colliding pulses: highest-priority one performs a read, error is set
  task automatic j_multi(input int sel);
    logic a, n, b;
    logic [7:0] addr;
    case (sel)
      0: begin a = 1; n = 1; b = 0; end
      1: begin a = 1; n = 0; b = 1; end
      2: begin a = 0; n = 1; b = 1; end
      default: begin a = 1; n = 1; b = 1; end
    endcase
    addr = rand_addr();
    jdo = jdo_a(1'b1, addr);
    if (a) m_addr = addr;
    else m_addr = m_addr + 8'd1;
    m_err  = 1'b1;
    m_dreg = m_mem[m_addr];
    jq.push_back('{m_dreg, m_err, 2});
    take_a = a; take_n = n; take_b = b;
    tick();
    take_a = 0; take_n = 0; take_b = 0;
    tick(); tick();
  endtask

  // read, with an extra pulse arriving while the sequencer is in J_RD
  task automatic j_busy(input logic [7:0] addr, input int which);
    jdo = jdo_a(1'b1, addr);
    m_addr = addr;
    m_dreg = m_mem[m_addr];
    m_err  = 1'b1;
    jq.push_back('{m_dreg, m_err, 2});
    take_a = 1'b1;
    tick();
    take_a = (which == 0);
    take_n = (which == 1);
    take_b = (which == 2);
    tick();
    take_a = 0; take_n = 0; take_b = 0;
    tick();
  endtask

  task automatic cpu_acc(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
    logic acc, w;
    acc = 1'b0;
    avs_address = addr; avs_write = wr; avs_read = rd;
    avs_writedata = data; avs_byteenable = be;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      w = avs_waitrequest;
      tick();
      if (w === 1'b0) acc = 1'b1;
    end
    avs_read = 1'b0; avs_write = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL cpu_timeout: got waitrequest=1 for 20 cycles want 0");
    end else if (wr) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) m_mem[addr][k*8 +: 8] = data[k*8 +: 8];
    end else if (rd) begin
      cq.push_back(m_mem[addr]);
      @(negedge clk);
      check32("cpu_rd_latency", {31'b0, avs_readdatavalid}, 32'd1);
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_mondreg"}, MonDReg, 32'h0);
    check32({tag, "_err"}, {31'b0, monitor_error}, 32'd0);
    check32({tag, "_ready"}, {31'b0, monitor_ready}, 32'd1);
    check32({tag, "_waitreq"}, {31'b0, avs_waitrequest}, 32'd0);
    check32({tag, "_rdvalid"}, {31'b0, avs_readdatavalid}, 32'd0);
    check32({tag, "_rdata"}, avs_readdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    reset = 1'b1;
    jdo = '0; take_a = 0; take_n = 0; take_b = 0;
    avs_address = '0; avs_read = 0; avs_write = 0;
    avs_writedata = '0; avs_byteenable = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_addr = '0; m_dreg = '0; m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check_reset_outputs("rst");

    // write word 0, then read it back
    j_b(32'hDEADBEEF);
    j_a(8'h00, 1'b1);

    // fill the rest of the RAM from the CPU side
    for (int i = 1; i < 256; i++) cpu_acc(1'b1, 1'b0, 8'(i), $urandom, 4'hF);

    // address wrap 0xFF -> 0x00
    j_a(8'hFF, 1'b0);
    j_n();

    // write into read-only window, then reload clears error and shows RAM intact
    j_a(8'hC5, 1'b0);
    j_b(32'h12345678);
    j_a(8'hC5, 1'b1);

    // CPU read collides with a JTAG read pulse
    jdo = jdo_a(1'b1, 8'h33);
    m_addr = 8'h33; m_err = 1'b0; m_dreg = m_mem[8'h33];
    jq.push_back('{m_dreg, m_err, 2});
    avs_address = 8'h10; avs_read = 1'b1; take_a = 1'b1;
    @(negedge clk);
    check32("wait_pulse", {31'b0, avs_waitrequest}, 32'd1);
    tick();
    take_a = 1'b0;
    @(negedge clk);
    check32("wait_j_rd", {31'b0, avs_waitrequest}, 32'd1);
    tick();
    @(negedge clk);
    check32("wait_j_cap", {31'b0, avs_waitrequest}, 32'd1);
    tick();
    @(negedge clk);
    check32("wait_idle", {31'b0, avs_waitrequest}, 32'd0);
    cq.push_back(m_mem[8'h10]);
    tick();
    avs_read = 1'b0;
    @(negedge clk);
    check32("collide_rdvalid", {31'b0, avs_readdatavalid}, 32'd1);
    tick();

    // extra pulse during J_RD
    j_busy(8'h05, 2);
    j_a(8'h06, 1'b1);

    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 8))
        0: j_a(rand_addr(), 1'b1);
        1: j_a(rand_addr(), 1'b0);
        2: j_n();
        3: j_b($urandom);
        4: cpu_acc(1'b1, 1'b0, rand_addr(), $urandom, 4'($urandom));
        5: cpu_acc(1'b0, 1'b1, rand_addr(), 32'h0, 4'hF);
        6: cpu_acc(1'b1, 1'b1, rand_addr(), $urandom, 4'($urandom));
        7: j_multi($urandom_range(0, 3));
        default: j_busy(rand_addr(), $urandom_range(0, 2));
      endcase
    end

    // reset while in J_WR: write dropped, outputs cleared
    j_a(8'h20, 1'b0);
    old = m_mem[8'h20];
    jdo = jdo_b(~old);
    jq.push_back('{32'h0, 1'b0, 1});
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    tick();
    reset = 1'b0;
    m_addr = '0; m_dreg = '0; m_err = 1'b0;
    tick();
    j_a(8'h20, 1'b1);

    repeat (3) tick();
    check32("jq_empty", jq.size(), 32'd0);
    check32("cq_empty", cq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicore_cpu_4_cpu_debug_ocimem.md
# multicore_cpu_4_cpu_debug_ocimem

Debug on-chip memory controller for one Nios II core of the multicore CPU. It sits directly downstream of the debug slave's system-clock stage and consumes its one-cycle `take_*_ocimem_*` pulses and the 38-bit `jdo` word. It performs JTAG-initiated reads and writes of a 256×32 debug RAM, sequences the address auto-increment, and returns read data on `MonDReg` with `monitor_ready`/`monitor_error` status. A CPU-side Avalon-MM slave port shares the same RAM; the JTAG side has priority.

## Interface
- `ADDR_W`, 8, word-address width of the debug RAM.
- `RO_BASE`, 8'hC0, first word of the JTAG-read-only region (`RO_BASE`..2^ADDR_W-1).
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `jdo` in 38: JTAG data word. Fields: [35] read-request flag, [33:26] address, [34:3] write data.
- `take_action_ocimem_a` in 1: load address; read if `jdo[35]`.
- `take_no_action_ocimem_a` in 1: increment address, then read.
- `take_action_ocimem_b` in 1: write `jdo[34:3]`, then increment address.
- `avs_address` in ADDR_W; `avs_read` in 1; `avs_write` in 1; `avs_writedata` in 32; `avs_byteenable` in 4.
- `avs_readdata` out 32; `avs_readdatavalid` out 1; `avs_waitrequest` out 1.
- `MonDReg` out 32: last JTAG read data.
- `monitor_ready` out 1: high iff the FSM is IDLE.
- `monitor_error` out 1: sticky error flag.

## Operation
- Registers: `mon_addr`[ADDR_W-1:0], `MonDReg`, `monitor_error`, FSM state. Address arithmetic is modulo 2^ADDR_W: 0xFF+1 → 0x00, with no error.
- FSM states: IDLE, J_RD, J_CAP, J_WR.
- IDLE + `take_action_ocimem_a`:
  - `mon_addr` ← `jdo[33:26]`; `monitor_error` ← 0.
  - If `jdo[35]`, go to J_RD; otherwise stay in IDLE.
- IDLE + `take_no_action_ocimem_a`: `mon_addr` ← `mon_addr`+1, then go to J_RD.
- IDLE + `take_action_ocimem_b`: go to J_WR.
- J_RD: drive RAM address = `mon_addr`, read enable; go to J_CAP.
- J_CAP: `MonDReg` ← RAM q; go to IDLE.
- J_WR:
  - If `mon_addr` < `RO_BASE`, write all 4 bytes of `jdo[34:3]`; otherwise suppress the write and set `monitor_error` ← 1.
  - In both cases `mon_addr` ← `mon_addr`+1 and go to IDLE.
- More than one take pulse in the same cycle: priority is `_a`, then `no_action_a`, then `_b`; the others are dropped and `monitor_error` ← 1.
- Any take pulse while not IDLE: dropped, `monitor_error` ← 1.
- `avs_waitrequest` = (state≠IDLE) | any take pulse (combinational).
- CPU accesses are accepted only when `avs_waitrequest`=0:
  - Write: byte-enabled, to any address. `RO_BASE` protection applies to JTAG writes only.
  - Read: `avs_readdata` is valid with `avs_readdatavalid`=1 exactly one cycle after acceptance.
  - `avs_read` and `avs_write` both high: treat as write only.
- `jdo` is sampled only in the pulse cycle (for `_a`) and in J_WR (for `_b`); upstream holds `jdo` stable through J_WR.

## Timing
- Reset values: `mon_addr`=0, `MonDReg`=0, `monitor_error`=0, state=IDLE (`monitor_ready`=1), `avs_readdata`=0, `avs_readdatavalid`=0, `avs_waitrequest`=0. RAM contents are not reset.
- JTAG read, pulse at cycle T:
  - T+1 J_RD, T+2 J_CAP.
  - `MonDReg` new and `monitor_ready`=1 at T+3.
- JTAG write, pulse at T:
  - T+1 J_WR; RAM written at the end of T+1.
  - `mon_addr` incremented and `monitor_ready`=1 at T+2.
- Address-only `_a` (`jdo[35]`=0): `mon_addr` updated at T+1; `monitor_ready` never drops.
- `avs_waitrequest` is high in T (same cycle as the pulse) through the last non-IDLE cycle.
- Reset asserted mid-operation aborts immediately: no RAM write if asserted before the J_WR edge, and `MonDReg` is cleared. A CPU `avs_readdatavalid` pending at reset is dropped.

## Structure
- Shared package `multicore_cpu_4_cpu_debug_pkg`: FSM state enum, `jdo` field-position localparams (RD_FLAG=35, ADDR_HI/LO=33/26, WDATA_HI/LO=34/3), default `RO_BASE`.
- One sub-module `multicore_cpu_4_cpu_debug_ocimem_ram`: single-port 2^ADDR_W×32, registered output, 4 byte enables. The controller muxes the JTAG/CPU port onto it.

## Test plan
- After reset, `take_action_ocimem_b` with `mon_addr`=0, `jdo[34:3]`=0xDEADBEEF → word0=0xDEADBEEF, `mon_addr`=1 at T+2, `monitor_error`=0.
- `take_action_ocimem_a`, `jdo[33:26]`=0x00, `jdo[35]`=1 → `MonDReg`=0xDEADBEEF at T+3; `monitor_ready` low in T+1..T+2 only.
- Load address 0xFF, then `take_no_action_ocimem_a` → reads word 0x00 (wrap), no error.
- JTAG write at `mon_addr`=0xC5 → RAM unchanged, `monitor_error`=1, `mon_addr`=0xC6; the next `take_action_ocimem_a` clears the error.
- CPU read at 0x10 asserted in the same cycle as a JTAG `_a` read pulse → `avs_waitrequest`=1 until IDLE; CPU data appears one cycle after acceptance.
- Second take pulse during J_RD → dropped, `monitor_error`=1, `MonDReg` from the first read intact. Reset in J_WR → no write, all outputs at reset values.
